// File: rtl/seven_segment_display_scan_if.sv
// Display-side bus of the seven-segment scanner: digit data and controls in,
// registered segment/digit drive and frame marker out.
interface seven_segment_display_scan_if #(
  parameter int unsigned w_digit  = 8,
  parameter int unsigned w_bright = 4
);
  logic [w_digit*4-1:0] number;
  logic [w_digit-1:0]   dots;
  logic [w_digit-1:0]   digit_en;
  logic                 lz_suppress;
  logic [w_bright-1:0]  brightness;
  logic                 hold;
  logic [7:0]           abcdefgh;
  logic [w_digit-1:0]   digit;
  logic                 frame_start;

  // master: the lab top-level supplying the value to show
  modport master (
    output number, dots, digit_en, lz_suppress, brightness, hold,
    input  abcdefgh, digit, frame_start
  );

  // slave: the scanner driving the display pins
  modport slave (
    input  number, dots, digit_en, lz_suppress, brightness, hold,
    output abcdefgh, digit, frame_start
  );
endinterface

// File: rtl/seven_segment_display_scan.sv
// Multiplexed N-digit seven-segment scanner: tear-free frame snapshots, per-digit
// enable, leading-zero suppression, PWM brightness, slot dead time, output polarity.
module seven_segment_display_scan #(
  parameter int unsigned w_digit        = 8,
  parameter int unsigned clk_mhz        = 50,
  parameter int unsigned refresh_hz     = 120,
  parameter int unsigned slot_override  = 0,
  parameter int unsigned blank_cycles   = 16,
  parameter int unsigned w_bright       = 4,
  parameter bit          seg_active_low = 1'b0,
  parameter bit          dig_active_low = 1'b0
) (
  input logic                        clk,
  input logic                        rst,
  seven_segment_display_scan_if.slave bus
);

  localparam int unsigned slot_auto = (clk_mhz * 1_000_000) / (refresh_hz * w_digit);
  localparam int unsigned slot_len  = (slot_override != 0) ? slot_override : slot_auto;
  localparam int unsigned sc_w      = (slot_len > 1) ? $clog2(slot_len) : 1;
  localparam int unsigned idx_w     = (w_digit > 1) ? $clog2(w_digit) : 1;

  typedef logic [w_digit-1:0][3:0] nib_vec_t;

  // scan state
  logic [sc_w-1:0]     sc_q,  sc_d;
  logic [idx_w-1:0]    idx_q, idx_d;
  logic [w_bright-1:0] p_q;

  // frame snapshot
  nib_vec_t            snap_num_q;
  logic [w_digit-1:0]  snap_dots_q;
  logic [w_digit-1:0]  snap_en_q;
  logic                snap_lz_q;

  // snapshot as seen this cycle (live inputs on the capture cycle)
  nib_vec_t            num_eff;
  logic [w_digit-1:0]  dots_eff;
  logic [w_digit-1:0]  en_eff;
  logic                lz_eff;

  logic                slot_end_c;
  logic                frame_cap_c;
  logic                take_c;
  logic                blank_done_c;
  logic [w_digit-1:0]  zero_c;
  logic [w_digit-1:0]  supp_vec_c;
  logic [3:0]          nib_c;
  logic [7:0]          font_c;
  logic                on_c;
  logic [7:0]          seg_c;
  logic [w_digit-1:0]  dig_c;

  // registered outputs
  logic [7:0]          seg_q;
  logic [w_digit-1:0]  dig_q;
  logic                fs_q;

  function automatic logic [7:0] hex_font(input logic [3:0] n);
    logic [7:0] f;
    case (n)
      4'h0: f = 8'hFC;
      4'h1: f = 8'h60;
      4'h2: f = 8'hDA;
      4'h3: f = 8'hF2;
      4'h4: f = 8'h66;
      4'h5: f = 8'hB6;
      4'h6: f = 8'hBE;
      4'h7: f = 8'hE0;
      4'h8: f = 8'hFE;
      4'h9: f = 8'hE6;
      4'hA: f = 8'hEE;
      4'hB: f = 8'h3E;
      4'hC: f = 8'h9C;
      4'hD: f = 8'h7A;
      4'hE: f = 8'h9E;
      4'hF: f = 8'h8E;
    endcase
    return f;
  endfunction

  // State register: scan position, PWM phase and frame snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_q        <= '0;
      idx_q       <= '0;
      p_q         <= '0;
      snap_num_q  <= '0;
      snap_dots_q <= '0;
      snap_en_q   <= '0;
      snap_lz_q   <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      idx_q <= idx_d;
      p_q   <= p_q + w_bright'(1);
      if (take_c) begin
        snap_num_q  <= num_eff;
        snap_dots_q <= dots_eff;
        snap_en_q   <= en_eff;
        snap_lz_q   <= lz_eff;
      end
    end
  end

  // Next-state: slot counter wraps into the digit index
  always_comb begin
    slot_end_c  = (sc_q == sc_w'(slot_len - 1));
    frame_cap_c = (sc_q == '0) && (idx_q == '0);
    take_c      = frame_cap_c && !bus.hold;
    sc_d        = slot_end_c ? '0 : sc_q + sc_w'(1);
    idx_d       = idx_q;
    if (slot_end_c) begin
      idx_d = (idx_q == idx_w'(w_digit - 1)) ? '0 : idx_q + idx_w'(1);
    end
  end

  assign num_eff  = take_c ? nib_vec_t'(bus.number) : snap_num_q;
  assign dots_eff = take_c ? bus.dots               : snap_dots_q;
  assign en_eff   = take_c ? bus.digit_en           : snap_en_q;
  assign lz_eff   = take_c ? bus.lz_suppress        : snap_lz_q;

  // A digit is blank-suppressed when it and every more significant nibble are zero
  for (genvar k = 0; k < w_digit; k++) begin : g_lz
    assign zero_c[k] = (num_eff[k] == 4'h0);
    if (k == 0) begin : g_lsd
      assign supp_vec_c[k] = 1'b0;
    end else begin : g_upper
      assign supp_vec_c[k] = lz_eff & (&zero_c[w_digit-1:k]);
    end
  end

  if (blank_cycles == 0) begin : g_no_blank
    assign blank_done_c = 1'b1;
  end else begin : g_blank
    assign blank_done_c = (sc_q >= sc_w'(blank_cycles));
  end

  // Output decode: segments only ever light together with their digit
  always_comb begin
    seg_c  = 8'h00;
    dig_c  = '0;
    nib_c  = num_eff[idx_q];
    font_c = hex_font(nib_c);
    on_c   = blank_done_c && en_eff[idx_q] &&
             ((bus.brightness == '1) || (p_q < bus.brightness));
    if (on_c) begin
      seg_c = {(supp_vec_c[idx_q] ? 7'h00 : font_c[7:1]), dots_eff[idx_q]};
      dig_c = w_digit'(1) << idx_q;
    end
  end

  // Segment and digit share one register stage so they never skew
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= {8{seg_active_low}};
      dig_q <= {w_digit{dig_active_low}};
      fs_q  <= 1'b0;
    end else begin
      seg_q <= seg_c ^ {8{seg_active_low}};
      dig_q <= dig_c ^ {w_digit{dig_active_low}};
      fs_q  <= frame_cap_c;
    end
  end

  assign bus.abcdefgh    = seg_q;
  assign bus.digit       = dig_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seven_segment_display_scan.sv
// Bench for seven_segment_display_scan: two instances (plain 8-cycle slots, and
// inverted-polarity 64-cycle slots with PWM) against a cycle scoreboard plus directed points.
module tb_seven_segment_display_scan;

  localparam int unsigned nd = 4;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seven_segment_display_scan_if #(.w_digit(nd), .w_bright(4)) ifa ();
  seven_segment_display_scan_if #(.w_digit(nd), .w_bright(4)) ifb ();

  seven_segment_display_scan #(
    .w_digit(nd), .clk_mhz(50), .refresh_hz(120), .slot_override(8), .blank_cycles(2),
    .w_bright(4), .seg_active_low(1'b0), .dig_active_low(1'b0)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

  seven_segment_display_scan #(
    .w_digit(nd), .clk_mhz(50), .refresh_hz(120), .slot_override(64), .blank_cycles(0),
    .w_bright(4), .seg_active_low(1'b1), .dig_active_low(1'b1)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  // live stimulus, index 0 -> dut_a, 1 -> dut_b
  logic [15:0] num_l  [2];
  logic [3:0]  dots_l [2];
  logic [3:0]  en_l   [2];
  logic [3:0]  br_l   [2];
  logic        lz_l   [2];
  logic        hold_l [2];

  assign ifa.number = num_l[0];  assign ifb.number = num_l[1];
  assign ifa.dots = dots_l[0];   assign ifb.dots = dots_l[1];
  assign ifa.digit_en = en_l[0]; assign ifb.digit_en = en_l[1];
  assign ifa.brightness = br_l[0]; assign ifb.brightness = br_l[1];
  assign ifa.lz_suppress = lz_l[0]; assign ifb.lz_suppress = lz_l[1];
  assign ifa.hold = hold_l[0];   assign ifb.hold = hold_l[1];

  // reference model state
  int          m_sc  [2];
  int          m_idx [2];
  int          m_p;
  logic [15:0] s_num [2];
  logic [3:0]  s_dots[2];
  logic [3:0]  s_en  [2];
  logic        s_lz  [2];

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int b_on  = 0;

  logic [7:0] oa_seg, ob_seg;
  logic [3:0] oa_dig, ob_dig;
  logic       oa_fs,  ob_fs;

  function automatic logic [7:0] font(input logic [3:0] n);
    logic [7:0] t [16];
    t = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
          8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    return t[n];
  endfunction

  function automatic int slot_of(input int u);
    return (u == 0) ? 8 : 64;
  endfunction

  function automatic int blank_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  // Expected registered outputs after the coming edge
  function automatic exp_t model_exp(input int u);
    exp_t        e;
    logic        take, lz, on, supp;
    logic [15:0] n;
    logic [3:0]  d, en;
    logic [7:0]  f;
    int          i;
    take = (m_idx[u] == 0) && (m_sc[u] == 0) && !hold_l[u];
    n    = take ? num_l[u]  : s_num[u];
    d    = take ? dots_l[u] : s_dots[u];
    en   = take ? en_l[u]   : s_en[u];
    lz   = take ? lz_l[u]   : s_lz[u];
    i    = m_idx[u];
    on   = (m_sc[u] >= blank_of(u)) && en[i] && ((br_l[u] == 4'hF) || (m_p < int'(br_l[u])));
    f    = font(n[i*4 +: 4]);
    supp = lz && (i > 0) && ((n >> (4*i)) == 16'h0);
    e.seg = on ? {(supp ? 7'h00 : f[7:1]), d[i]} : 8'h00;
    e.dig = on ? 4'(1 << i) : 4'h0;
    e.fs  = (m_idx[u] == 0) && (m_sc[u] == 0);
    if (u == 1) begin
      e.seg = ~e.seg;
      e.dig = ~e.dig;
    end
    return e;
  endfunction

  task automatic model_advance(input int u);
    if ((m_idx[u] == 0) && (m_sc[u] == 0) && !hold_l[u]) begin
      s_num[u]  = num_l[u];
      s_dots[u] = dots_l[u];
      s_en[u]   = en_l[u];
      s_lz[u]   = lz_l[u];
    end
    if (m_sc[u] == slot_of(u) - 1) begin
      m_sc[u]  = 0;
      m_idx[u] = (m_idx[u] + 1) % nd;
    end else begin
      m_sc[u]  = m_sc[u] + 1;
    end
  endtask

  task automatic model_reset();
    m_p = 0;
    for (int u = 0; u < 2; u++) begin
      m_sc[u] = 0; m_idx[u] = 0;
      s_num[u] = '0; s_dots[u] = '0; s_en[u] = '0; s_lz[u] = 1'b0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] seg, input logic [3:0] dig);
    chk({tag, "_a_seg"}, 32'(oa_seg), 32'(seg));
    chk({tag, "_a_dig"}, 32'(oa_dig), 32'(dig));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] seg, input logic [3:0] dig);
    chk({tag, "_b_seg"}, 32'(ob_seg), 32'(seg));
    chk({tag, "_b_dig"}, 32'(ob_dig), 32'(dig));
  endtask

  // One clock: push expectations, clock, pop and compare both instances
  task automatic step();
    exp_t e;
    q_a.push_back(model_exp(0));
    q_b.push_back(model_exp(1));
    @(posedge clk);
    model_advance(0);
    model_advance(1);
    m_p = (m_p + 1) % 16;
    #1;
    cyc++;
    oa_seg = ifa.abcdefgh; oa_dig = ifa.digit; oa_fs = ifa.frame_start;
    ob_seg = ifb.abcdefgh; ob_dig = ifb.digit; ob_fs = ifb.frame_start;
    if (ob_dig != 4'hF) b_on++;
    e = q_a.pop_front();
    chk("sb_a_seg", 32'(oa_seg), 32'(e.seg));
    chk("sb_a_dig", 32'(oa_dig), 32'(e.dig));
    chk("sb_a_fs",  32'(oa_fs),  32'(e.fs));
    e = q_b.pop_front();
    chk("sb_b_seg", 32'(ob_seg), 32'(e.seg));
    chk("sb_b_dig", 32'(ob_dig), 32'(e.dig));
    chk("sb_b_fs",  32'(ob_fs),  32'(e.fs));
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    num_l[0] = 16'h1234; dots_l[0] = 4'h0; en_l[0] = 4'hF; br_l[0] = 4'hF; lz_l[0] = 1'b0; hold_l[0] = 1'b0;
    num_l[1] = 16'h1234; dots_l[1] = 4'h0; en_l[1] = 4'b1011; br_l[1] = 4'h4; lz_l[1] = 1'b0; hold_l[1] = 1'b0;
    model_reset();

    // reset values
    #12;
    oa_seg = ifa.abcdefgh; oa_dig = ifa.digit; ob_seg = ifb.abcdefgh; ob_dig = ifb.digit;
    chk_a("rst", 8'h00, 4'h0);
    chk_b("rst", 8'hFF, 4'hF);
    chk("rst_a_fs", 32'(ifa.frame_start), 32'h0);
    chk("rst_b_fs", 32'(ifb.frame_start), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // basic scan, 8-cycle slots, 2 dead cycles
    step();
    chk("first_a_fs", 32'(oa_fs), 32'h1);
    chk("first_b_fs", 32'(ob_fs), 32'h1);
    chk_a("dead", 8'h00, 4'h0);
    run_to(3);   chk_a("d0_4", 8'h66, 4'b0001); chk_b("pwm_on", 8'h99, 4'b1110);
    run_to(5);   chk_b("pwm_off", 8'hFF, 4'hF);
    run_to(11);  chk_a("d1_3", 8'hF2, 4'b0010);
    run_to(32);  chk_a("d3_1", 8'h60, 4'b1000); chk("fs_gap", 32'(oa_fs), 32'h0);
    run_to(33);  chk("fs_32", 32'(oa_fs), 32'h1);

    // mid-frame change is deferred to the next frame
    run_to(49);  num_l[0] = 16'h5678;
    run_to(51);  chk_a("mid_2", 8'hDA, 4'b0100);
    run_to(59);  chk_a("mid_1", 8'h60, 4'b1000);
    run_to(64);  chk("pwm_quarter", 32'(b_on), 32'd16); b_on = 0;
    run_to(67);  chk_a("nf_8", 8'hFE, 4'b0001);
    run_to(75);  chk_a("nf_7", 8'hE0, 4'b0010);

    // hold freezes the snapshot but frame_start keeps pulsing
    hold_l[0] = 1'b1; num_l[0] = 16'h9ABC;
    run_to(97);  chk("hold_fs", 32'(oa_fs), 32'h1);
    run_to(99);  chk_a("hold_8", 8'hFE, 4'b0001);
    hold_l[0] = 1'b0;
    run_to(130); chk_b("dis_d2", 8'hFF, 4'hF);
    run_to(131); chk_a("unhold_C", 8'h9C, 4'b0001);

    // leading-zero suppression
    lz_l[0] = 1'b1; num_l[0] = 16'h0070;
    run_to(163); chk_a("lz_d0", 8'hFC, 4'b0001);
    run_to(171); chk_a("lz_d1", 8'hE0, 4'b0010);
    run_to(179); chk_a("lz_d2", 8'h00, 4'b0100);
    run_to(187); chk_a("lz_d3", 8'h00, 4'b1000);
    num_l[0] = 16'h0000; dots_l[0] = 4'b1000;
    run_to(192); br_l[1] = 4'h0; b_on = 0;
    run_to(195); chk_a("lz0_d0", 8'hFC, 4'b0001);
    run_to(203); chk_a("lz0_d1", 8'h00, 4'b0010);
    run_to(219); chk_a("lz0_dot", 8'h01, 4'b1000);
    run_to(256); chk("pwm_zero", 32'(b_on), 32'd0); br_l[1] = 4'hF; b_on = 0;
    run_to(320); chk("pwm_full", 32'(b_on), 32'd64);

    // asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    oa_seg = ifa.abcdefgh; oa_dig = ifa.digit; ob_seg = ifb.abcdefgh; ob_dig = ifb.digit;
    chk_a("async_rst", 8'h00, 4'h0);
    chk_b("async_rst", 8'hFF, 4'hF);
    chk("async_a_fs", 32'(ifa.frame_start), 32'h0);
    @(posedge clk);
    #1;
    oa_seg = ifa.abcdefgh; oa_dig = ifa.digit; ob_seg = ifb.abcdefgh; ob_dig = ifb.digit;
    chk_a("rst_held", 8'h00, 4'h0);
    chk_b("rst_held", 8'hFF, 4'hF);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    step();
    chk("rel_a_fs", 32'(oa_fs), 32'h1);
    chk("rel_b_fs", 32'(ob_fs), 32'h1);
    chk_a("rel_dead", 8'h00, 4'h0);
    run_to(3);   chk_a("rel_d0", 8'hFC, 4'b0001);
    run_to(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
